// File: rtl/uart_bus_bridge_if.sv
// uart_bus_bridge_if
// Signal bundle between the UART/bus bridge and its surroundings.
//   UART data-register port:
//     uart_dat_do  [31:0] receive register, 32'hFFFFFFFF when empty
//     uart_dat_re         pulse that consumes the received byte
//     uart_dat_we         pulse that starts transmission of uart_dat_di[7:0]
//     uart_dat_di  [31:0] transmit byte, upper bits zero
//     uart_dat_ack        pulse when the UART has finished shifting a byte
//   Native memory bus (valid/ready):
//     mem_valid, mem_ready, mem_addr, mem_wdata, mem_wstrb, mem_rdata
// The bridge connects through the master modport; the UART and the bus
// target (or a testbench standing in for them) use the slave modport.
interface uart_bus_bridge_if;
    logic [31:0] uart_dat_do;
    logic        uart_dat_re;
    logic        uart_dat_we;
    logic [31:0] uart_dat_di;
    logic        uart_dat_ack;

    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        input  uart_dat_do, uart_dat_ack, mem_ready, mem_rdata,
        output uart_dat_re, uart_dat_we, uart_dat_di,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        output uart_dat_do, uart_dat_ack, mem_ready, mem_rdata,
        input  uart_dat_re, uart_dat_we, uart_dat_di,
               mem_valid, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
// Host-debug bridge: pulls command frames from the UART receive register,
// performs one 32-bit bus read or write per frame and returns a response
// through the UART transmit register.
//   Frames (LSB first):  write = 57 a0 a1 a2 a3 d0 d1 d2 d3
//                        read  = 52 a0 a1 a2 a3
//   Responses:           write = status; read = status d0 d1 d2 d3
//                        status 4B = ok, 45 = bus timeout (read data FFFFFFFF)
// Ports:
//   clk     system clock
//   resetn  asynchronous active-low reset
//   br      uart_bus_bridge_if.master (UART data-register port + memory bus)
//   busy    high whenever the bridge is not waiting for a command byte
// Parameters:
//   BUS_TIMEOUT  cycles mem_valid may wait for mem_ready (0 disables)
//   RX_GAP       idle cycles allowed inside a frame before it is dropped (0 disables)
module uart_bus_bridge #(
    parameter int unsigned BUS_TIMEOUT = 32'd4096,
    parameter int unsigned RX_GAP      = 32'd1000000
) (
    input  logic              clk,
    input  logic              resetn,
    uart_bus_bridge_if.master br,
    output logic              busy
);
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] STAT_OK   = 8'h4B;
    localparam logic [7:0] STAT_ERR  = 8'h45;

    // TX_SEND/TX_WAIT together form the transmit phase: one cycle to pulse
    // uart_dat_we, then wait for the UART to report the byte as shifted.
    typedef enum logic [2:0] {
        ST_RX_CMD,
        ST_RX_ADDR,
        ST_RX_DATA,
        ST_BUS,
        ST_TX_SEND,
        ST_TX_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        re_q;
    logic        op_write_q;
    logic [1:0]  rx_idx_q;
    logic [2:0]  tx_idx_q;
    logic [31:0] gap_cnt_q;
    logic [31:0] bus_cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [7:0]  status_q;

    logic        rx_state;
    logic        byte_valid;
    logic [7:0]  rx_byte;
    logic        gap_hit;
    logic        bus_to;
    logic        tx_last;
    logic [7:0]  tx_byte;

    assign rx_state = (state_q == ST_RX_CMD) || (state_q == ST_RX_ADDR) ||
                      (state_q == ST_RX_DATA);
    // The UART register still shows the consumed byte in the cycle right
    // after a read strobe, so that cycle is skipped.
    assign byte_valid = rx_state && !re_q && (br.uart_dat_do != 32'hFFFF_FFFF);
    assign rx_byte    = br.uart_dat_do[7:0];

    // Both limits fire on the edge where the count would reach the limit.
    assign gap_hit = (RX_GAP != 32'd0) && (gap_cnt_q >= RX_GAP - 32'd1);
    assign bus_to  = (BUS_TIMEOUT != 32'd0) && (bus_cnt_q >= BUS_TIMEOUT - 32'd1);

    assign tx_last = op_write_q ? (tx_idx_q == 3'd0) : (tx_idx_q == 3'd4);

    always_comb begin
        tx_byte = 8'h00;
        case (tx_idx_q)
            3'd0:    tx_byte = status_q;
            3'd1:    tx_byte = rdata_q[7:0];
            3'd2:    tx_byte = rdata_q[15:8];
            3'd3:    tx_byte = rdata_q[23:16];
            3'd4:    tx_byte = rdata_q[31:24];
            default: tx_byte = 8'h00;
        endcase
    end

    // NOTE: non-blocking assignments for every flop so all state updates
    // see the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_RX_CMD;
        else         state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RX_CMD: begin
                if (byte_valid && (rx_byte == OP_WRITE || rx_byte == OP_READ))
                    state_d = ST_RX_ADDR;
            end
            ST_RX_ADDR: begin
                if (byte_valid) begin
                    if (rx_idx_q == 2'd3) state_d = op_write_q ? ST_RX_DATA : ST_BUS;
                end else if (gap_hit) begin
                    state_d = ST_RX_CMD;
                end
            end
            ST_RX_DATA: begin
                if (byte_valid) begin
                    if (rx_idx_q == 2'd3) state_d = ST_BUS;
                end else if (gap_hit) begin
                    state_d = ST_RX_CMD;
                end
            end
            ST_BUS: begin
                if (br.mem_ready || bus_to) state_d = ST_TX_SEND;
            end
            ST_TX_SEND: state_d = ST_TX_WAIT;
            ST_TX_WAIT: begin
                if (br.uart_dat_ack) state_d = tx_last ? ST_RX_CMD : ST_TX_SEND;
            end
            default: state_d = ST_RX_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            re_q       <= 1'b0;
            op_write_q <= 1'b0;
            rx_idx_q   <= 2'd0;
            tx_idx_q   <= 3'd0;
            gap_cnt_q  <= 32'd0;
            bus_cnt_q  <= 32'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            status_q   <= 8'h00;
        end else begin
            re_q <= byte_valid;

            // Counters restart on every state entry and saturate instead of
            // wrapping, so a disabled limit can never alias to a match.
            if (state_d != state_q) begin
                gap_cnt_q <= 32'd0;
                bus_cnt_q <= 32'd0;
            end else begin
                if (state_q == ST_RX_ADDR || state_q == ST_RX_DATA) begin
                    if (byte_valid)                gap_cnt_q <= 32'd0;
                    else if (gap_cnt_q != '1)      gap_cnt_q <= gap_cnt_q + 32'd1;
                end
                if (state_q == ST_BUS && bus_cnt_q != '1)
                    bus_cnt_q <= bus_cnt_q + 32'd1;
            end

            case (state_q)
                ST_RX_CMD: begin
                    if (byte_valid && (rx_byte == OP_WRITE || rx_byte == OP_READ)) begin
                        op_write_q <= (rx_byte == OP_WRITE);
                        rx_idx_q   <= 2'd0;
                    end
                end
                ST_RX_ADDR: begin
                    if (byte_valid) begin
                        addr_q   <= {rx_byte, addr_q[31:8]};
                        rx_idx_q <= rx_idx_q + 2'd1;
                    end
                end
                ST_RX_DATA: begin
                    if (byte_valid) begin
                        wdata_q  <= {rx_byte, wdata_q[31:8]};
                        rx_idx_q <= rx_idx_q + 2'd1;
                    end
                end
                ST_BUS: begin
                    tx_idx_q <= 3'd0;
                    // Ready wins over a timeout landing on the same edge.
                    if (br.mem_ready) begin
                        rdata_q  <= br.mem_rdata;
                        status_q <= STAT_OK;
                    end else if (bus_to) begin
                        rdata_q  <= 32'hFFFF_FFFF;
                        status_q <= STAT_ERR;
                    end
                end
                ST_TX_WAIT: begin
                    if (br.uart_dat_ack && !tx_last) tx_idx_q <= tx_idx_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign br.uart_dat_re = byte_valid;
    assign br.uart_dat_we = (state_q == ST_TX_SEND);
    assign br.uart_dat_di = {24'h0, tx_byte};
    assign br.mem_valid   = (state_q == ST_BUS);
    assign br.mem_addr    = addr_q;
    assign br.mem_wdata   = wdata_q;
    assign br.mem_wstrb   = (state_q == ST_BUS && op_write_q) ? 4'hF : 4'h0;
    assign busy           = (state_q != ST_RX_CMD);
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge
// Self-checking bench for uart_bus_bridge. A combined UART/memory model
// feeds received bytes from a queue, acknowledges transmitted bytes after a
// fixed delay and answers bus requests after a programmable number of
// cycles. Expected bus accesses and response bytes are queued when a frame
// is sent and compared as the bridge produces them.
module tb_uart_bus_bridge;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cycles;   // expected mem_valid length, 0 = not checked
    } bus_exp_t;

    logic clk;
    logic resetn;
    logic busy;

    uart_bus_bridge_if ifc ();

    uart_bus_bridge #(
        .BUS_TIMEOUT(8),
        .RX_GAP     (100)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .br    (ifc),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    bus_exp_t   bus_q[$];
    int         ready_after = -1;
    logic [31:0] rdata_val  = 32'h0;
    int         re_cnt      = 0;

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) rx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic expect_read_resp(input logic [7:0] status, input logic [31:0] d);
        tx_q.push_back(status);
        for (int i = 0; i < 4; i++) tx_q.push_back(d[8*i +: 8]);
    endtask

    // UART + memory target model: samples DUT outputs at the falling edge,
    // updates its own outputs 1 time unit after the rising edge.
    initial begin : uart_mem_model
        bit          re_s;
        bit          ack_wait;
        int          vcount;
        int          ack_cnt;
        logic [31:0] addr_p;
        logic [31:0] wdata_p;
        logic [3:0]  wstrb_p;
        bus_exp_t    cur;

        re_s     = 1'b0;
        ack_wait = 1'b0;
        vcount   = 0;
        ack_cnt  = 0;
        addr_p   = 32'h0;
        wdata_p  = 32'h0;
        wstrb_p  = 4'h0;
        cur      = '{32'h0, 32'h0, 4'h0, 0};
        ifc.uart_dat_do  = 32'hFFFF_FFFF;
        ifc.uart_dat_ack = 1'b0;
        ifc.mem_ready    = 1'b0;
        ifc.mem_rdata    = 32'h0;

        forever begin
            @(negedge clk);
            if (ifc.mem_valid) begin
                if (vcount == 0) begin
                    check("bus_expected", 32'(bus_q.size() != 0), 32'd1);
                    if (bus_q.size() != 0) begin
                        cur = bus_q.pop_front();
                        check("bus_addr", ifc.mem_addr, cur.addr);
                        check("bus_wstrb", 32'(ifc.mem_wstrb), 32'(cur.wstrb));
                        if (cur.wstrb == 4'hF) check("bus_wdata", ifc.mem_wdata, cur.wdata);
                    end
                end else begin
                    check("addr_stable", ifc.mem_addr, addr_p);
                    check("wdata_stable", ifc.mem_wdata, wdata_p);
                    check("wstrb_stable", 32'(ifc.mem_wstrb), 32'(wstrb_p));
                end
                vcount++;
            end else if (vcount != 0) begin
                if (cur.cycles != 0) check("valid_cycles", 32'(vcount), 32'(cur.cycles));
                vcount = 0;
            end
            addr_p  = ifc.mem_addr;
            wdata_p = ifc.mem_wdata;
            wstrb_p = ifc.mem_wstrb;

            if (ifc.uart_dat_we) begin
                check("we_after_ack", 32'(ack_wait), 32'd0);
                check("tx_expected", 32'(tx_q.size() != 0), 32'd1);
                if (tx_q.size() != 0) check("tx_byte", ifc.uart_dat_di, {24'h0, tx_q.pop_front()});
                ack_wait = 1'b1;
                ack_cnt  = 3;
            end
            re_s = ifc.uart_dat_re;

            @(posedge clk);
            #1;
            if (re_s) begin
                re_cnt++;
                if (rx_q.size() != 0) rx_q.delete(0);
            end
            ifc.uart_dat_do = (rx_q.size() != 0) ? {24'h0, rx_q[0]} : 32'hFFFF_FFFF;

            if (ifc.uart_dat_ack) ack_wait = 1'b0;
            ifc.uart_dat_ack = 1'b0;
            if (ack_wait) begin
                ack_cnt--;
                if (ack_cnt == 0) ifc.uart_dat_ack = 1'b1;
            end

            ifc.mem_ready = ifc.mem_valid && (ready_after >= 0) && (vcount == ready_after);
            ifc.mem_rdata = ifc.mem_ready ? rdata_val : 32'h0BAD_0BAD;
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((busy || rx_q.size() != 0 || tx_q.size() != 0 || bus_q.size() != 0) && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check({tag, "_done"}, 32'(n < 2000), 32'd1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int re0;
        int n;

        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #2;

        // Reset state
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_valid", 32'(ifc.mem_valid), 32'd0);
        check("rst_we",    32'(ifc.uart_dat_we), 32'd0);
        check("rst_re",    32'(ifc.uart_dat_re), 32'd0);
        check("rst_di",    ifc.uart_dat_di, 32'd0);
        check("rst_addr",  ifc.mem_addr, 32'd0);
        check("rst_wdata", ifc.mem_wdata, 32'd0);
        check("rst_wstrb", 32'(ifc.mem_wstrb), 32'd0);

        // Write: ready in the 4th valid cycle
        re0 = re_cnt;
        ready_after = 3;
        bus_q.push_back('{32'h2000_0010, 32'hDEAD_BEEF, 4'hF, 4});
        tx_q.push_back(8'h4B);
        rx_q.push_back(8'h57);
        push_word(32'h2000_0010);
        push_word(32'hDEAD_BEEF);
        wait_done("wr");
        check("wr_re_count", 32'(re_cnt - re0), 32'd9);

        // Read: ready in the first valid cycle
        re0 = re_cnt;
        ready_after = 0;
        rdata_val = 32'h1234_5678;
        bus_q.push_back('{32'h0200_0004, 32'h0, 4'h0, 1});
        expect_read_resp(8'h4B, 32'h1234_5678);
        rx_q.push_back(8'h52);
        push_word(32'h0200_0004);
        wait_done("rd");
        check("rd_re_count", 32'(re_cnt - re0), 32'd5);

        // Unknown command bytes (including 0xFF) are consumed and dropped
        re0 = re_cnt;
        ready_after = 1;
        rdata_val = 32'hA5A5_0001;
        bus_q.push_back('{32'h0000_0008, 32'h0, 4'h0, 2});
        expect_read_resp(8'h4B, 32'hA5A5_0001);
        rx_q.push_back(8'hFF);
        rx_q.push_back(8'h00);
        rx_q.push_back(8'h41);
        rx_q.push_back(8'h52);
        push_word(32'h0000_0008);
        wait_done("unk");
        check("unk_re_count", 32'(re_cnt - re0), 32'd8);

        // Bus timeout: ready never comes, valid lasts exactly 8 cycles
        ready_after = -1;
        bus_q.push_back('{32'h4000_0000, 32'h0, 4'h0, 8});
        expect_read_resp(8'h45, 32'hFFFF_FFFF);
        rx_q.push_back(8'h52);
        push_word(32'h4000_0000);
        wait_done("tmo");

        // RX gap: partial write frame dropped after 100 idle cycles
        re0 = re_cnt;
        rx_q.push_back(8'h57);
        rx_q.push_back(8'h10);
        rx_q.push_back(8'h00);
        n = 0;
        while (rx_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("gap_consumed", 32'(rx_q.size()), 32'd0);
        repeat (99) @(posedge clk);
        #3;
        check("gap_before_limit", 32'(busy), 32'd1);
        @(posedge clk);
        #3;
        check("gap_at_limit", 32'(busy), 32'd0);
        ready_after = 2;
        rdata_val = 32'h0BEE_F00D;
        bus_q.push_back('{32'h0000_0104, 32'h0, 4'h0, 3});
        expect_read_resp(8'h4B, 32'h0BEE_F00D);
        rx_q.push_back(8'h52);
        push_word(32'h0000_0104);
        wait_done("gap");
        check("gap_re_count", 32'(re_cnt - re0), 32'd8);

        // Asynchronous reset in the middle of a bus access
        ready_after = -1;
        bus_q.push_back('{32'h0000_0100, 32'h0, 4'h0, 0});
        rx_q.push_back(8'h52);
        push_word(32'h0000_0100);
        n = 0;
        while (!ifc.mem_valid && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("rst_reach_bus", 32'(ifc.mem_valid), 32'd1);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_async_valid", 32'(ifc.mem_valid), 32'd0);
        check("rst_async_busy",  32'(busy), 32'd0);
        check("rst_async_we",    32'(ifc.uart_dat_we), 32'd0);
        @(posedge clk);
        #2 resetn = 1'b1;
        @(posedge clk);
        #2;
        check("rst_rel_busy", 32'(busy), 32'd0);

        // Normal write after reset
        ready_after = 2;
        bus_q.push_back('{32'h3000_0004, 32'h0000_CAFE, 4'hF, 3});
        tx_q.push_back(8'h4B);
        rx_q.push_back(8'h57);
        push_word(32'h3000_0004);
        push_word(32'h0000_CAFE);
        wait_done("post_rst");

        check("end_bus_q", 32'(bus_q.size()), 32'd0);
        check("end_tx_q",  32'(tx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
